// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div_4 iterative restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Quotient reported for a zero divisor: all ones at the requested width.
    function automatic logic [31:0] div_zero_quo(input int width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step; borrow means the trial failed.
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_div_4.sv
// Iterative restoring divider, one trial subtraction per cycle, valid/ready on both sides.
// Optional signed (truncating) division is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div_4
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] DIV_ZERO_QUO = WIDTH'(div_zero_quo(WIDTH));
    localparam logic [CW-1:0]    CNT_LOAD     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};

    div_state_t       state_r, state_nxt_s;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic [WIDTH-1:0] rem_r, rem_nxt_s, quo_r, quo_nxt_s, dvs_r, dvs_nxt_s;
    logic             dbz_r, dbz_nxt_s;
    logic [WIDTH-1:0] dd_mag_s, dv_mag_s, step_rem_s, step_quo_s;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic             borrow_s, diff_msb_unused_s;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_r, neg_q_nxt_s, neg_r_r, neg_r_nxt_s, neg_q_s, neg_r_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitudes and result signs captured at accept time.
    always_comb begin
        neg_q_s  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_s  = is_signed & dividend[WIDTH-1];
        dd_mag_s = (is_signed && dividend[WIDTH-1]) ? neg_w(dividend) : dividend;
        dv_mag_s = (is_signed && divisor[WIDTH-1])  ? neg_w(divisor)  : divisor;
    end
`else
    assign dd_mag_s = dividend;
    assign dv_mag_s = divisor;
`endif

    // Partial remainder shifted left, pulling in the next dividend bit from quo_r.
    assign rem_sh_s          = {rem_r, quo_r[WIDTH-1]};
    assign diff_msb_unused_s = diff_s[WIDTH];

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .a      (rem_sh_s),
        .b      ({1'b0, dvs_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // Restore on borrow, otherwise keep the difference and set the quotient bit.
    always_comb begin
        if (borrow_s) begin
            step_rem_s = rem_sh_s[WIDTH-1:0];
        end else begin
            step_rem_s = diff_s[WIDTH-1:0];
        end
        step_quo_s = {quo_r[WIDTH-2:0], ~borrow_s};
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        rem_nxt_s   = rem_r;
        quo_nxt_s   = quo_r;
        dvs_nxt_s   = dvs_r;
        dbz_nxt_s   = dbz_r;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q_nxt_s = neg_q_r;
        neg_r_nxt_s = neg_r_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    count_nxt_s = CNT_LOAD;
                    dvs_nxt_s   = dv_mag_s;
`ifdef SEQ_DIV_SIGNED_EN
                    neg_q_nxt_s = neg_q_s;
                    neg_r_nxt_s = neg_r_s;
`endif
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_nxt_s = DONE;
                        quo_nxt_s   = DIV_ZERO_QUO;
                        rem_nxt_s   = dividend;
                        dbz_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = BUSY;
                        quo_nxt_s   = dd_mag_s;
                        rem_nxt_s   = {WIDTH{1'b0}};
                        dbz_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                rem_nxt_s = step_rem_s;
                quo_nxt_s = step_quo_s;
                if (count_r == {CW{1'b0}}) begin
                    state_nxt_s = DONE;
`ifdef SEQ_DIV_SIGNED_EN
                    quo_nxt_s = neg_q_r ? neg_w(step_quo_s) : step_quo_s;
                    rem_nxt_s = neg_r_r ? neg_w(step_rem_s) : step_rem_s;
`endif
                end else begin
                    count_nxt_s = count_r - CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers; a reset mid-division discards the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            count_r <= count_nxt_s;
            rem_r   <= rem_nxt_s;
            quo_r   <= quo_nxt_s;
            dvs_r   <= dvs_nxt_s;
            dbz_r   <= dbz_nxt_s;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r <= neg_q_nxt_s;
            neg_r_r <= neg_r_nxt_s;
`endif
        end
    end

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = (state_r == DONE);
    assign quotient    = quo_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_div_4.sv
// Scoreboard-based bench for seq_div_4 (WIDTH=4); signed cases run when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_4;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [3:0] dividend, divisor, quotient, remainder;
`ifdef SEQ_DIV_SIGNED_EN
    logic       is_signed;
`endif

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    seq_div_4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] dd, input logic [3:0] dv, input logic sgn);
        res_t m;
        int   a, b;
        if (dv == 4'd0) begin
            m.q = 4'hF; m.r = dd; m.dbz = 1'b1;
        end else if (sgn) begin
            a = int'($signed(dd));
            b = int'($signed(dv));
            m.q = 4'(a / b); m.r = 4'(a % b); m.dbz = 1'b0;
        end else begin
            m.q = dd / dv; m.r = dd % dv; m.dbz = 1'b0;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] dd, input logic [3:0] dv, input logic sgn);
        dividend = dd;
        divisor  = dv;
`ifdef SEQ_DIV_SIGNED_EN
        is_signed = sgn;
`endif
        in_valid = 1'b1;
        exp_q.push_back(model(dd, dv, sgn));
    endtask

    // Returns once the accept edge has passed; ok=0 if in_ready never came.
    task automatic accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // Edges waited after the accept edge before out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; dividend = 4'd0; divisor = 4'd0;
`ifdef SEQ_DIV_SIGNED_EN
        is_signed = 1'b0;
`endif
        step(); step();
        checks++;
        if ({quotient, remainder, div_by_zero, out_valid} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h dbz=%b ov=%b, expected all 0",
                     quotient, remainder, div_by_zero, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Runs one request to completion with out_ready=1, checking latency and result.
    task automatic test_single(input string name, input logic [3:0] dd, input logic [3:0] dv,
                               input logic sgn);
        bit   ok;
        int   cyc, lat;
        res_t e, got;
        out_ready = 1'b1;
        drive(dd, dv, sgn);
        accept(ok);
        wait_valid(cyc);
        lat = (dv == 4'd0) ? 1 : 5;
        checks++;
        if (!ok || cyc + 1 != lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (accepted=%0b), expected %0d", name, cyc + 1, ok, lat);
        end
        e   = exp_q.pop_front();
        got = '{quotient, remainder, div_by_zero};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     name, got.q, got.r, got.dbz, e.q, e.r, e.dbz);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: got ov=%b ir=%b, expected ov=0 ir=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   cyc;
        res_t e;
        out_ready = 1'b0;
        drive(4'd15, 4'd1, 1'b0);
        accept(ok);
        wait_valid(cyc);
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {quotient, remainder, div_by_zero} !== e) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b q=%h r=%h, expected ov=1 ir=0 q=%h r=%h",
                         i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_transfer: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int bad = 0;
        drive(4'd9, 4'd4, 1'b0);
        void'(exp_q.pop_back());
        accept(ok);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, div_by_zero, out_valid} !== 10'd0) begin
            errors++;
            $display("FAIL abort_outputs: got q=%h r=%h dbz=%b ov=%b, expected all 0",
                     quotient, remainder, div_by_zero, out_valid);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abort_stale: %0d cycles with ov=1 or ir=0, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int   seen = 0, acc = 0;
        res_t e, got;
        out_ready = 1'b1;
        drive(4'd2, 4'd3, 1'b0);
        for (int i = 0; i < 40 && seen < 2; i++) begin
            checks++;
            if (in_ready && out_valid) begin
                errors++; $display("FAIL b2b_overlap: in_ready and out_valid both 1 at cycle %0d", i);
            end
            if (out_valid) begin
                got = '{quotient, remainder, div_by_zero};
                e   = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                             seen, got.q, got.r, got.dbz, e.q, e.r, e.dbz);
                end
                seen++;
            end
            if (in_ready && in_valid) begin
                acc++;
                step();
                if (acc == 1) begin
                    dividend = 4'd3; divisor = 4'd2;
                    exp_q.push_back(model(4'd3, 4'd2, 1'b0));
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        checks++;
        if (seen != 2 || acc != 2) begin
            errors++; $display("FAIL b2b_count: got %0d results %0d accepts, expected 2 and 2", seen, acc);
        end
        step();
    endtask

    task automatic test_random();
        logic [3:0] dd, dv;
        for (int i = 0; i < 10; i++) begin
            dd = 4'($urandom_range(0, 15));
            dv = (i % 4 == 3) ? 4'd0 : 4'($urandom_range(1, 15));
            test_single("rand", dd, dv, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single("div13_3", 4'd13, 4'd3, 1'b0);
        test_single("div7_0", 4'd7, 4'd0, 1'b0);
        test_single("div6_2", 4'd6, 4'd2, 1'b0);
        test_backpressure();
        test_reset_abort();
`ifdef SEQ_DIV_SIGNED_EN
        test_single("sdiv_m7_2", 4'h9, 4'h2, 1'b1);
        test_single("sdiv_m8_m1", 4'h8, 4'hF, 1'b1);
        test_single("sdiv_7_m2", 4'h7, 4'hE, 1'b1);
        test_single("sdiv_m3_0", 4'hD, 4'h0, 1'b1);
`endif
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d results left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
